// File: rtl/ultrasonic_ranger.sv
`default_nettype none
// ============================================================================
//  Module      : ultrasonic_ranger
//  Description : HC-SR04 driver. Fires a trigger pulse once per frame,
//                measures the synchronised echo width, and maps it onto a
//                four-level duty code for the downstream motor PWM stage.
//                Missing and over-range echoes are flagged and given safe
//                duty codes (stop / full).
//  Revision    : 1.0 - initial release
// ============================================================================
module ultrasonic_ranger #(
    parameter int unsigned TRIG_CYCLES   = 1000,
    parameter int unsigned ECHO_TIMEOUT  = 3802000,
    parameter int unsigned PERIOD_CYCLES = 6000000,
    parameter int unsigned BAND_CYCLES   = 475250,
    parameter int unsigned PWM_PERIOD    = 250000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        echo,
    output logic        trig,
    output logic [18:0] pulse_width,
    output logic [22:0] echo_width,
    output logic        sample_valid,
    output logic        no_echo,
    output logic        over_range
);

    // Counter compare points, all resolved at elaboration.
    localparam logic [22:0] C_TRIG_LAST    = 23'(TRIG_CYCLES - 1);
    localparam logic [22:0] C_TIMEOUT      = 23'(ECHO_TIMEOUT);
    localparam logic [22:0] C_TIMEOUT_LAST = 23'(ECHO_TIMEOUT - 1);
    localparam logic [22:0] C_FRAME_LAST   = 23'(PERIOD_CYCLES - 1);
    localparam logic [22:0] C_BAND1        = 23'(BAND_CYCLES);
    localparam logic [22:0] C_BAND2        = 23'(2 * BAND_CYCLES);
    localparam logic [22:0] C_BAND3        = 23'(3 * BAND_CYCLES);

    // Duty codes handed to the PWM stage.
    localparam logic [18:0] C_DUTY_Q1   = 19'(PWM_PERIOD / 4);
    localparam logic [18:0] C_DUTY_Q2   = 19'(PWM_PERIOD / 2);
    localparam logic [18:0] C_DUTY_Q3   = 19'((3 * PWM_PERIOD) / 4);
    localparam logic [18:0] C_DUTY_FULL = 19'(PWM_PERIOD);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_TRIG      = 3'd1,
        ST_WAIT_RISE = 3'd2,
        ST_MEASURE   = 3'd3,
        ST_HOLDOFF   = 3'd4
    } state_t;

    state_t      r_state;
    logic        r_echo_meta;
    logic        r_echo_s;
    logic [22:0] r_fcnt;
    logic [22:0] r_wcnt;
    logic [18:0] w_duty;

    // Echo width to duty band; widths above the third band mean a clear path.
    function automatic logic [18:0] map_width(input logic [22:0] w);
        if (w <= C_BAND1)
            return C_DUTY_Q1;
        else if (w <= C_BAND2)
            return C_DUTY_Q2;
        else if (w <= C_BAND3)
            return C_DUTY_Q3;
        else
            return C_DUTY_FULL;
    endfunction

    assign w_duty = map_width(r_wcnt);

    // Two-stage synchroniser for the asynchronous echo input.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_echo_meta <= 1'b0;
            r_echo_s    <= 1'b0;
        end else begin
            r_echo_meta <= echo;
            r_echo_s    <= r_echo_meta;
        end
    end

    // Frame sequencer: trigger, wait for echo, measure, hold off to frame end.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_fcnt       <= '0;
            r_wcnt       <= '0;
            trig         <= 1'b0;
            pulse_width  <= '0;
            echo_width   <= '0;
            sample_valid <= 1'b0;
            no_echo      <= 1'b0;
            over_range   <= 1'b0;
        end else begin
            sample_valid <= 1'b0;
            // Frame counter saturates so a stretched holdoff cannot wrap it.
            if (r_fcnt != C_FRAME_LAST)
                r_fcnt <= r_fcnt + 23'd1;

            case (r_state)
                ST_IDLE: begin
                    r_state <= ST_TRIG;
                    trig    <= 1'b1;
                    r_fcnt  <= '0;
                end

                ST_TRIG: begin
                    // fcnt starts at 0 on trig rise, so trig stays high TRIG_CYCLES cycles.
                    if (r_fcnt == C_TRIG_LAST) begin
                        trig    <= 1'b0;
                        r_wcnt  <= '0;
                        r_state <= ST_WAIT_RISE;
                    end
                end

                ST_WAIT_RISE: begin
                    if (r_echo_s) begin
                        r_wcnt  <= 23'd1;
                        r_state <= ST_MEASURE;
                    end else if (r_wcnt == C_TIMEOUT_LAST) begin
                        // Sensor fault: stop the motor.
                        pulse_width  <= '0;
                        echo_width   <= '0;
                        no_echo      <= 1'b1;
                        over_range   <= 1'b0;
                        sample_valid <= 1'b1;
                        r_state      <= ST_HOLDOFF;
                    end else begin
                        r_wcnt <= r_wcnt + 23'd1;
                    end
                end

                ST_MEASURE: begin
                    if (!r_echo_s) begin
                        echo_width   <= r_wcnt;
                        pulse_width  <= w_duty;
                        no_echo      <= 1'b0;
                        over_range   <= 1'b0;
                        sample_valid <= 1'b1;
                        r_state      <= ST_HOLDOFF;
                    end else if (r_wcnt >= C_TIMEOUT) begin
                        // Echo never returned in range: report full scale without waiting.
                        echo_width   <= C_TIMEOUT;
                        pulse_width  <= C_DUTY_FULL;
                        no_echo      <= 1'b0;
                        over_range   <= 1'b1;
                        sample_valid <= 1'b1;
                        r_state      <= ST_HOLDOFF;
                    end else begin
                        r_wcnt <= r_wcnt + 23'd1;
                    end
                end

                ST_HOLDOFF: begin
                    // A still-high echo stretches the frame until it drops.
                    if ((r_fcnt == C_FRAME_LAST) && !r_echo_s) begin
                        trig    <= 1'b1;
                        r_fcnt  <= '0;
                        r_state <= ST_TRIG;
                    end
                end

                default: begin
                    trig    <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ultrasonic_ranger.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ultrasonic_ranger
//  Description : Directed self-checking bench for ultrasonic_ranger, run with
//                shrunken timing parameters (trig 10, timeout 380, frame 600,
//                band 50) so that every frame type fits in a short run.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ultrasonic_ranger;

    localparam int TRIG   = 10;
    localparam int TMO    = 380;
    localparam int PERIOD = 600;
    localparam int BAND   = 50;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        echo = 1'b0;
    logic        trig;
    logic [18:0] pulse_width;
    logic [22:0] echo_width;
    logic        sample_valid;
    logic        no_echo;
    logic        over_range;

    ultrasonic_ranger #(
        .TRIG_CYCLES   (TRIG),
        .ECHO_TIMEOUT  (TMO),
        .PERIOD_CYCLES (PERIOD),
        .BAND_CYCLES   (BAND),
        .PWM_PERIOD    (250000)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .echo         (echo),
        .trig         (trig),
        .pulse_width  (pulse_width),
        .echo_width   (echo_width),
        .sample_valid (sample_valid),
        .no_echo      (no_echo),
        .over_range   (over_range)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    // Strobe monitor, sampled on the falling edge.
    int     strobe_cnt = 0;
    int     strobe_dbl = 0;
    int     last_cyc = -1;
    longint last_pw = 0;
    longint last_ew = 0;
    logic   last_ne = 1'b0;
    logic   last_or = 1'b0;
    logic   sv_prev = 1'b0;
    always @(negedge clk) begin
        if (sample_valid) begin
            strobe_cnt = strobe_cnt + 1;
            last_cyc   = cyc;
            last_pw    = longint'(pulse_width);
            last_ew    = longint'(echo_width);
            last_ne    = no_echo;
            last_or    = over_range;
            if (sv_prev) strobe_dbl = strobe_dbl + 1;
        end
        sv_prev = sample_valid;
    end

    int     rise;
    longint prev_pw = 0;

    task automatic check(input string tag, input longint obs, input longint exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wait_trig(input logic lvl, input int budget, output int at);
        at = -1;
        for (int n = 0; n < budget; n++) begin
            @(negedge clk);
            if (trig === lvl) begin
                at = cyc;
                break;
            end
        end
        tests++;
        assert (at >= 0) else begin
            fails++;
            $error("FAIL wait_trig: observed timeout expected trig=%0b within %0d cycles", lvl, budget);
        end
    endtask

    // One frame with an echo of w cycles starting right after trig falls.
    task automatic run_frame(input int w, input longint exp_pw);
        int f, r2, s0;
        s0 = strobe_cnt;
        wait_trig(1'b0, TRIG + 5, f);
        check("trig_width", longint'(f - rise), TRIG);
        check("pw_hold", longint'(pulse_width), prev_pw);
        echo = 1'b1;
        repeat (w) @(negedge clk);
        echo = 1'b0;
        wait_trig(1'b1, PERIOD + 50, r2);
        check("frame_spacing", longint'(r2 - rise), PERIOD);
        check("strobe_count", longint'(strobe_cnt - s0), 1);
        check("strobe_latency", longint'(last_cyc), longint'(f + w + 3));
        check("echo_width", last_ew, longint'(w));
        check("pulse_width", last_pw, exp_pw);
        check("no_echo", longint'(last_ne), 0);
        check("over_range", longint'(last_or), 0);
        rise    = r2;
        prev_pw = exp_pw;
    endtask

    initial begin
        int rel, f, r2, s0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_trig", longint'(trig), 0);
        check("rst_pw", longint'(pulse_width), 0);
        check("rst_ew", longint'(echo_width), 0);
        check("rst_sv", longint'(sample_valid), 0);
        check("rst_ne", longint'(no_echo), 0);
        check("rst_or", longint'(over_range), 0);
        reset = 1'b0;
        rel   = cyc;
        wait_trig(1'b1, 5, rise);
        check("first_trig", longint'(rise - rel), 1);

        // Reset in the middle of the trigger pulse
        repeat (5) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("t1_trig_async", longint'(trig), 0);
        check("t1_pw", longint'(pulse_width), 0);
        check("t1_sv", longint'(sample_valid), 0);
        @(negedge clk);
        reset = 1'b0;
        rel   = cyc;
        check("t1_trig_released", longint'(trig), 0);
        wait_trig(1'b1, 5, rise);
        check("t1_retrig", longint'(rise - rel), 1);

        // Normal frames across band edges
        run_frame(30,  62500);
        run_frame(51,  125000);
        run_frame(100, 125000);
        run_frame(151, 250000);
        run_frame(150, 187500);

        // No echo
        s0 = strobe_cnt;
        wait_trig(1'b0, TRIG + 5, f);
        check("ne_trig_width", longint'(f - rise), TRIG);
        wait_trig(1'b1, PERIOD + 50, r2);
        check("ne_spacing", longint'(r2 - rise), PERIOD);
        check("ne_strobe_count", longint'(strobe_cnt - s0), 1);
        check("ne_latency", longint'(last_cyc), longint'(f + TMO));
        check("ne_pw", last_pw, 0);
        check("ne_ew", last_ew, 0);
        check("ne_flag", longint'(last_ne), 1);
        check("ne_or", longint'(last_or), 0);
        rise = r2;

        // Echo held high past the frame end
        s0 = strobe_cnt;
        wait_trig(1'b0, TRIG + 5, f);
        echo = 1'b1;
        repeat (700) @(negedge clk);
        echo = 1'b0;
        wait_trig(1'b1, 50, r2);
        check("or_retrig", longint'(r2), longint'(f + 703));
        check("or_strobe_count", longint'(strobe_cnt - s0), 1);
        check("or_latency", longint'(last_cyc), longint'(f + TMO + 3));
        check("or_ew", last_ew, TMO);
        check("or_pw", last_pw, 250000);
        check("or_flag", longint'(last_or), 1);
        check("or_ne", longint'(last_ne), 0);
        rise = r2;

        // Echo already high when the wait-for-rise begins
        s0 = strobe_cnt;
        repeat (3) @(negedge clk);
        echo = 1'b1;
        wait_trig(1'b0, TRIG + 5, f);
        check("early_trig_width", longint'(f - rise), TRIG);
        repeat (20) @(negedge clk);
        echo = 1'b0;
        wait_trig(1'b1, PERIOD + 50, r2);
        check("early_spacing", longint'(r2 - rise), PERIOD);
        check("early_strobe_count", longint'(strobe_cnt - s0), 1);
        check("early_latency", longint'(last_cyc), longint'(f + 23));
        check("early_ew", last_ew, 22);
        check("early_pw", last_pw, 62500);
        check("early_or_cleared", longint'(last_or), 0);
        check("early_ne", longint'(last_ne), 0);

        check("strobe_single_cycle", longint'(strobe_dbl), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
